// File: rtl/mskaes_req_arbiter.sv
// Two-requester round-robin front end for a masked AES core: grants one
// shared plaintext/key at a time, forwards the result, and schedules PRNG reseeds.
module mskaes_req_arbiter #(
  parameter int d             = 2,
  parameter int RESEED_PERIOD = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [128*d-1:0] req0_plaintext,
  input  logic [128*d-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [128*d-1:0] req1_plaintext,
  input  logic [128*d-1:0] req1_key,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [128*d-1:0] rsp_ciphertext,
  output logic             aes_valid_in,
  input  logic             aes_ready,
  output logic [128*d-1:0] aes_plaintext,
  output logic [128*d-1:0] aes_key,
  input  logic             aes_cipher_valid,
  input  logic [128*d-1:0] aes_ciphertext,
  output logic             prng_start_reseed,
  input  logic             prng_out_valid
);

  localparam int W  = 128 * d;
  localparam int CW = (RESEED_PERIOD > 0) ? $clog2(RESEED_PERIOD + 1) : 1;
  localparam logic [CW-1:0] CNT_P   = CW'(RESEED_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_RESEED, S_WAIT_PRNG, S_IDLE, S_START, S_BUSY, S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   enc_cnt_q, enc_cnt_d;
  logic [W-1:0]    pt_q, pt_d, key_q, key_d, ct_q, ct_d;
  logic            id_q, id_d;

  logic [1:0]          req_v, req_rdy;
  logic [1:0][W-1:0]   req_pt, req_key;
  logic                gnt;

  assign req_v   = {req1_valid, req0_valid};
  assign req_pt  = {req1_plaintext, req0_plaintext};
  assign req_key = {req1_key, req0_key};

  // Contended: alternate away from the last winner; otherwise take whoever asks.
  assign gnt = (&req_v) ? ~last_grant_q : req_v[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    enc_cnt_d    = enc_cnt_q;
    pt_d         = pt_q;
    key_d        = key_q;
    ct_d         = ct_q;
    id_d         = id_q;
    req_rdy      = '0;
    case (state_q)
      S_RESEED: begin
        enc_cnt_d = '0;
        state_d   = S_WAIT_PRNG;
      end
      S_WAIT_PRNG: if (prng_out_valid) state_d = S_IDLE;
      S_IDLE: begin
        if (aes_ready && prng_out_valid && |req_v) begin
          req_rdy[gnt] = 1'b1;
          last_grant_d = gnt;
          id_d         = gnt;
          pt_d         = req_pt[gnt];
          key_d        = req_key[gnt];
          state_d      = S_START;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (aes_cipher_valid) begin
          ct_d = aes_ciphertext;
          if (enc_cnt_q != CNT_MAX) enc_cnt_d = enc_cnt_q + CW'(1);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (RESEED_PERIOD != 0 && enc_cnt_q == CNT_P) state_d = S_RESEED;
        else                                          state_d = S_IDLE;
      end
      default: state_d = S_RESEED;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_RESEED;
      last_grant_q <= 1'b1;
      enc_cnt_q    <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      ct_q         <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      enc_cnt_q    <= enc_cnt_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      ct_q         <= ct_d;
      id_q         <= id_d;
    end
  end

  assign req0_ready     = req_rdy[0];
  assign req1_ready     = req_rdy[1];
  assign aes_valid_in   = (state_q == S_START);
  assign rsp_valid      = (state_q == S_RESP);
  // Reset parks the FSM in RESEED, but the pulse must stay low while nrst is held.
  assign prng_start_reseed = (state_q == S_RESEED) & nrst;
  assign aes_plaintext  = pt_q;
  assign aes_key        = key_q;
  assign rsp_ciphertext = ct_q;
  assign rsp_id         = id_q;

endmodule

// File: tb/tb_mskaes_req_arbiter.sv
// Bench for mskaes_req_arbiter: transaction-level reference model, a fake masked
// AES core with random latency, directed scenarios and a randomized soak.
module tb_mskaes_req_arbiter;
  localparam int D = 2;
  localparam int W = 128 * D;
  localparam int P = 2;
  localparam logic [127:0] KEY_V = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] PT_V  = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] CT_V  = 128'h320b6a19978511dcfb09dc021d842539;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [W-1:0] req0_plaintext = '0, req0_key = '0, req1_plaintext = '0, req1_key = '0;
  logic rsp_valid, rsp_id, aes_valid_in, prng_start_reseed;
  logic [W-1:0] rsp_ciphertext, aes_plaintext, aes_key;
  logic aes_ready = 1'b0, aes_cipher_valid = 1'b0, prng_out_valid = 1'b0;
  logic [W-1:0] aes_ciphertext = '0;

  always #5 clk = ~clk;

  mskaes_req_arbiter #(.d(D), .RESEED_PERIOD(P)) dut (
    .clk(clk), .nrst(nrst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_plaintext(req0_plaintext), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_plaintext(req1_plaintext), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ciphertext(rsp_ciphertext),
    .aes_valid_in(aes_valid_in), .aes_ready(aes_ready),
    .aes_plaintext(aes_plaintext), .aes_key(aes_key),
    .aes_cipher_valid(aes_cipher_valid), .aes_ciphertext(aes_ciphertext),
    .prng_start_reseed(prng_start_reseed), .prng_out_valid(prng_out_valid)
  );

  int checks = 0, errors = 0;

  // scenario knobs
  logic       t_nrst = 1'b0, t_rdy = 1'b1, t_prng = 1'b0, t_spur = 1'b0;
  logic [1:0] t_v = 2'b00;
  int         t_lat = 0;
  logic [W-1:0] r_pt[2], r_key[2];

  // fake AES core
  int           core_cnt = 0;
  bit           core_start = 0;
  logic [127:0] core_pt, core_key;

  // reference model: which protocol phase is outstanding, plus the live transaction
  bit           m_reseed, m_wprng, m_start, m_wres, m_rsp, m_last, m_id;
  int           m_cnt;
  logic [W-1:0] m_pt, m_key, m_ct;
  logic [127:0] m_exp;

  // samples of the last checked cycle, for directed scenarios
  bit           s_r0, s_r1, s_reseed, s_rspv, s_rspid;
  logic [127:0] s_ct_plain;

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] share(input logic [127:0] x);
    logic [W-1:0] s;
    logic acc, b;
    for (int i = 0; i < 128; i++) begin
      acc = 1'b0;
      for (int j = 0; j < D - 1; j++) begin
        b = 1'($urandom_range(0, 1));
        s[D*i + j] = b;
        acc ^= b;
      end
      s[D*i + D - 1] = x[i] ^ acc;
    end
    return s;
  endfunction

  function automatic logic [127:0] unshare(input logic [W-1:0] s);
    logic [127:0] x;
    for (int i = 0; i < 128; i++) begin
      x[i] = 1'b0;
      for (int j = 0; j < D; j++) x[i] ^= s[D*i + j];
    end
    return x;
  endfunction

  // Stand-in cipher: the known answer for the reference vector, a keyed mix otherwise.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    if (pt == PT_V && key == KEY_V) return CT_V;
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_0f0f_5a5a_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic bit m_idle();
    return !(m_reseed || m_wprng || m_start || m_wres || m_rsp);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_reseed = 1; m_wprng = 0; m_start = 0; m_wres = 0; m_rsp = 0;
    m_last = 1; m_cnt = 0;
  endtask

  // One clock: drive just after the rising edge, check and advance the model at the falling edge.
  task automatic cycle();
    logic         cv, can, gid, hs0, hs1;
    logic [W-1:0] ct;
    logic [4:0]   exp_ctrl;
    if (!t_nrst) core_cnt = 0;
    else if (core_start) core_cnt = (t_lat > 0) ? t_lat : int'($urandom_range(1, 4));
    core_start = 0;
    cv = 1'b0;
    ct = rnd_w();
    if (core_cnt == 1) begin
      cv = 1'b1; ct = share(aes_ref(core_pt, core_key)); core_cnt = 0;
    end else if (core_cnt > 1) core_cnt--;
    else if (t_spur && $urandom_range(0, 5) == 0) cv = 1'b1;
    nrst = t_nrst;
    req0_valid = t_v[0]; req1_valid = t_v[1];
    req0_plaintext = r_pt[0]; req0_key = r_key[0];
    req1_plaintext = r_pt[1]; req1_key = r_key[1];
    aes_ready = t_rdy && (core_cnt == 0);
    prng_out_valid = t_prng;
    aes_cipher_valid = cv;
    aes_ciphertext = ct;

    @(negedge clk);
    s_r0 = req0_ready; s_r1 = req1_ready; s_reseed = prng_start_reseed;
    s_rspv = rsp_valid; s_rspid = rsp_id; s_ct_plain = unshare(rsp_ciphertext);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (!nrst) begin
      model_reset();
      chk("reset_ctrl", {req0_ready, req1_ready, aes_valid_in, rsp_valid, prng_start_reseed, rsp_id}, '0);
      chk("reset_data", aes_plaintext | aes_key | rsp_ciphertext, '0);
    end else begin
      can = m_idle() && aes_ready && prng_out_valid && (req0_valid || req1_valid);
      gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
      exp_ctrl = {can && !gid, can && gid, m_start, m_rsp, m_reseed};
      chk("ctrl", {req0_ready, req1_ready, aes_valid_in, rsp_valid, prng_start_reseed}, exp_ctrl);
      if (m_start) begin
        chk("aes_plaintext", aes_plaintext, m_pt);
        chk("aes_key", aes_key, m_key);
      end
      if (m_rsp) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_ciphertext", rsp_ciphertext, m_ct);
        chk("rsp_recombined", s_ct_plain, m_exp);
      end
      if (m_reseed) begin
        m_reseed = 0; m_wprng = 1; m_cnt = 0;
      end else if (m_wprng) begin
        if (prng_out_valid) m_wprng = 0;
      end else if (can) begin
        m_id = gid; m_last = gid;
        m_pt  = gid ? req1_plaintext : req0_plaintext;
        m_key = gid ? req1_key : req0_key;
        m_exp = aes_ref(unshare(m_pt), unshare(m_key));
        m_start = 1;
      end else if (m_start) begin
        m_start = 0; m_wres = 1;
      end else if (m_wres) begin
        if (aes_cipher_valid) begin
          m_wres = 0; m_rsp = 1; m_ct = aes_ciphertext; m_cnt++;
        end
      end else if (m_rsp) begin
        m_rsp = 0;
        if (m_cnt == P) m_reseed = 1;
      end
      if (aes_valid_in) begin
        core_start = 1;
        core_pt = unshare(aes_plaintext);
        core_key = unshare(aes_key);
      end
    end

    @(posedge clk);
    #1;
    if (hs0) begin r_pt[0] = share(rnd128()); r_key[0] = share(rnd128()); end
    if (hs1) begin r_pt[1] = share(rnd128()); r_key[1] = share(rnd128()); end
  endtask

  task automatic do_reset();
    t_nrst = 1'b0;
    repeat (2) cycle();
    t_nrst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int pulses, gcyc, ng, nr, rc;
    bit rsp_seen;
    r_pt[0] = share(PT_V);     r_key[0] = share(KEY_V);
    r_pt[1] = share(rnd128()); r_key[1] = share(rnd128());

    // Boot: PRNG ready 3 cycles after release, then the known-answer request from req0
    t_nrst = 1'b0; t_v = 2'b00; t_rdy = 1'b1; t_prng = 1'b0;
    repeat (3) cycle();
    t_nrst = 1'b1; t_v = 2'b01;
    pulses = 0; gcyc = -1; rsp_seen = 0;
    for (int c = 0; c < 40; c++) begin
      t_prng = (c >= 3);
      cycle();
      if (s_reseed) pulses++;
      if (s_r0 && gcyc < 0) begin gcyc = c; t_v = 2'b00; end
      if (s_rspv) begin
        rsp_seen = 1;
        chk("kat_rsp_id", s_rspid, 0);
        chk("kat_ciphertext", s_ct_plain, CT_V);
        break;
      end
    end
    chk("boot_reseed_pulses", pulses, 1);
    chk("boot_grant_cycle", gcyc, 4);
    chk("kat_rsp_seen", rsp_seen, 1);

    // Both requesters held valid: 0,1,0,1 from reset
    t_v = 2'b00; do_reset();
    t_prng = 1'b1; t_v = 2'b11; ng = 0;
    for (int c = 0; c < 400 && ng < 4; c++) begin
      cycle();
      if (s_r0 || s_r1) begin
        chk($sformatf("rr_grant%0d", ng), s_r1, ng % 2);
        ng++;
      end
    end
    chk("rr_grants_seen", ng, 4);

    // Back-to-back requests: reseed right after the 2nd response, then wait for PRNG
    t_v = 2'b00; do_reset();
    t_prng = 1'b1; t_v = 2'b01; nr = 0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (nr == 2) begin chk("reseed_after_2nd_rsp", s_reseed, 1); break; end
      if (s_rspv) nr++;
    end
    chk("rsp_before_reseed", nr, 2);
    t_prng = 1'b0;
    repeat (6) begin cycle(); chk("wait_prng_no_grant", s_r0, 0); end
    t_prng = 1'b1;
    cycle(); chk("prng_sampled_no_grant", s_r0, 0);
    cycle(); chk("grant_after_prng", s_r0, 1);
    t_v = 2'b00;

    // req1 blocked by aes_ready, then by prng_out_valid
    for (int c = 0; c < 60; c++) begin cycle(); if (m_idle()) break; end
    chk("drain_timeout", m_idle(), 1);
    t_v = 2'b10; t_rdy = 1'b0; t_prng = 1'b1;
    repeat (3) begin cycle(); chk("r1_blocked_aes", s_r1, 0); end
    t_rdy = 1'b1; t_prng = 1'b0;
    repeat (3) begin cycle(); chk("r1_blocked_prng", s_r1, 0); end
    t_prng = 1'b1;
    cycle(); chk("r1_granted", s_r1, 1);
    t_v = 2'b00;

    // Reset while the core is busy: transaction is dropped
    for (int c = 0; c < 60; c++) begin cycle(); if (m_idle()) break; end
    t_lat = 4; t_v = 2'b01;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (s_r0) t_v = 2'b00;
      if (m_wres) break;
    end
    chk("reached_busy", m_wres, 1);
    rc = 0;
    t_nrst = 1'b0;
    repeat (2) begin cycle(); if (s_rspv) rc++; end
    t_nrst = 1'b1;
    cycle(); chk("post_reset_reseed", s_reseed, 1);
    repeat (12) begin cycle(); if (s_rspv) rc++; end
    chk("no_rsp_after_abort", rc, 0);
    t_lat = 0;

    // Randomized soak with spurious core results, PRNG drops and occasional resets
    t_spur = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      t_v    = 2'($urandom_range(0, 3));
      t_rdy  = ($urandom_range(0, 7) != 0);
      t_prng = ($urandom_range(0, 7) != 0);
      t_nrst = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
